// File: rtl/cache_dma_engine_if.sv
// Word-beat memory bus between the DMA engine (master) and main memory (slave).
// mem_ack_i may be driven combinationally from mem_req_o by the slave.
interface cache_dma_engine_if #(
    parameter int unsigned MEM_WIDTH = 32
) ();
    logic                 mem_req_o;
    logic                 mem_we_o;
    logic [31:0]          mem_addr_o;
    logic [MEM_WIDTH-1:0] mem_wdata_o;
    logic [MEM_WIDTH-1:0] mem_rdata_i;
    logic                 mem_ack_i;

    modport master (
        output mem_req_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_wdata_o,
        input  mem_rdata_i,
        input  mem_ack_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_wdata_o,
        output mem_rdata_i,
        output mem_ack_i
    );
endinterface

// File: rtl/cache_dma_engine.sv
// Block refill / eviction engine: serialises one cache block at a time onto a
// word-beat memory bus and returns fills or eviction acks as one-cycle pulses.
module cache_dma_engine #(
    parameter int unsigned BLOCK_BITS = 512,
    parameter int unsigned MEM_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  req_i,
    input  logic [31:0]           req_addr_i,
    input  logic                  evict_i,
    input  logic [31:0]           evict_addr_i,
    input  logic [BLOCK_BITS-1:0] evict_data_i,
    output logic [BLOCK_BITS-1:0] fill_data_o,
    output logic [31:0]           fill_addr_o,
    output logic                  fill_valid_o,
    output logic                  evict_ack_o,
    output logic                  busy_o,
    cache_dma_engine_if.master    mem
);
    localparam int unsigned BEATS  = BLOCK_BITS / MEM_WIDTH;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned IDX_W  = $clog2(BLOCK_BITS);
    localparam int unsigned OFF_W  = $clog2(BLOCK_BITS / 8);

    localparam logic [31:0]       BEAT_BYTES = 32'(MEM_WIDTH / 8);
    localparam logic [31:0]       BASE_MASK  = ~((32'd1 << OFF_W) - 32'd1);
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BEATS - 1);
    localparam logic [IDX_W-1:0]  LANE_BITS  = IDX_W'(MEM_WIDTH);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StWb     = 3'd1;
    localparam logic [2:0] StWbDone = 3'd2;
    localparam logic [2:0] StRd     = 3'd3;
    localparam logic [2:0] StRdDone = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [31:0]           base_q, base_d;
    logic [BLOCK_BITS-1:0] buf_q, buf_d;
    logic [BLOCK_BITS-1:0] fill_q, fill_d;

    logic             in_xfer;
    logic [IDX_W-1:0] lane_lsb;

    assign in_xfer  = (state_q == StWb) || (state_q == StRd);
    assign lane_lsb = IDX_W'(beat_q) * LANE_BITS;

    // buf_q holds the eviction block during WB and accumulates read beats during RD;
    // fill_q only changes when a refill completes so the cache sees a stable block.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        base_d  = base_q;
        buf_d   = buf_q;
        fill_d  = fill_q;
        unique case (state_q)
            StIdle: begin
                if (evict_i) begin
                    state_d = StWb;
                    base_d  = evict_addr_i & BASE_MASK;
                    buf_d   = evict_data_i;
                    beat_d  = '0;
                end else if (req_i) begin
                    state_d = StRd;
                    base_d  = req_addr_i & BASE_MASK;
                    beat_d  = '0;
                end
            end
            StWb, StRd: begin
                if (mem.mem_ack_i) begin
                    if (state_q == StRd) begin
                        buf_d[lane_lsb +: MEM_WIDTH] = mem.mem_rdata_i;
                    end
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        beat_d = '0;
                        if (state_q == StRd) begin
                            state_d = StRdDone;
                            fill_d  = buf_d;
                        end else begin
                            state_d = StWbDone;
                        end
                    end
                end
            end
            StWbDone, StRdDone: state_d = StIdle;
            default:            state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= StIdle;
            beat_q  <= '0;
            base_q  <= '0;
            buf_q   <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            base_q  <= base_d;
            buf_q   <= buf_d;
            fill_q  <= fill_d;
        end
    end

    assign mem.mem_req_o   = in_xfer;
    assign mem.mem_we_o    = (state_q == StWb);
    assign mem.mem_addr_o  = in_xfer ? (base_q + 32'(beat_q) * BEAT_BYTES) : '0;
    assign mem.mem_wdata_o = (state_q == StWb) ? buf_q[lane_lsb +: MEM_WIDTH] : '0;

    assign fill_data_o  = fill_q;
    assign fill_addr_o  = (state_q == StRdDone) ? base_q : '0;
    assign fill_valid_o = (state_q == StRdDone);
    assign evict_ack_o  = (state_q == StWbDone);
    assign busy_o       = (state_q != StIdle);
endmodule
